// File: rtl/fifo_rd_fwft_if.sv
// Signal bundle for the FWFT read stage: FIFO read port on one side, valid/ready stream on the other.
// The stage itself is the master; the surrounding FIFO and consumer form the slave side.
interface fifo_rd_fwft_if #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 2
);
    localparam int LVL_W = $clog2(BUF_DEPTH) + 1;

    logic             fifo_empty;
    logic             rd_inr;
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LVL_W-1:0] buf_level;

    modport master (
        input  fifo_empty,
        input  ram_rdata,
        input  out_ready,
        output rd_inr,
        output out_data,
        output out_valid,
        output buf_level
    );

    modport slave (
        output fifo_empty,
        output ram_rdata,
        output out_ready,
        input  rd_inr,
        input  out_data,
        input  out_valid,
        input  buf_level
    );
endinterface

// File: rtl/fifo_rd_fwft.sv
// Read-side output stage of the async FIFO: turns the registered empty flag and the
// 1-cycle RAM read port into a first-word-fall-through valid/ready stream.
module fifo_rd_fwft #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic           rclk,
    input  logic           rst_n,
    fifo_rd_fwft_if.master bus
);
    localparam int             PTR_W   = $clog2(BUF_DEPTH);
    localparam int             LVL_W   = PTR_W + 1;
    localparam logic [LVL_W:0] DEPTH_W = (LVL_W + 1)'(BUF_DEPTH);

    logic [WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] buf_level;
    logic             inflight;
    logic             init;
    logic             pop;
    logic [LVL_W:0]   credit;

    // Credit counts the word already on its way from the RAM, so the buffer can never overflow.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns every output on every path, so no latch is inferred.
        pop        = (buf_level != '0) & bus.out_ready;
        credit     = {1'b0, buf_level} + (LVL_W + 1)'(inflight) - (LVL_W + 1)'(pop);
        bus.rd_inr = ~init & ~bus.fifo_empty & (credit < DEPTH_W);
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
        if (!rst_n) begin
            init      <= 1'b1;
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_level <= '0;
        end else begin
            init      <= 1'b0;
            inflight  <= bus.rd_inr;
            buf_level <= credit[LVL_W-1:0];
            if (inflight) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: the buffer is reset because out_data must read 0 after reset; it is only BUF_DEPTH words.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
        end else if (inflight) begin
            buf_mem[wr_ptr] <= bus.ram_rdata;
        end
    end

    assign bus.out_data  = buf_mem[rd_ptr];
    assign bus.out_valid = (buf_level != '0);
    assign bus.buf_level = buf_level;
endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: an upstream FIFO model serves words from a source array, and each
// scenario task checks the output stream against that array in order.
module tb_fifo_rd_fwft;
    localparam int W     = 8;
    localparam int D     = 4;
    localparam int LVL_W = $clog2(D) + 1;
    localparam int NSRC  = 16384;

    logic rclk  = 1'b0;
    logic rst_n = 1'b0;
    always #5 rclk = ~rclk;

    fifo_rd_fwft_if #(.WIDTH(W), .BUF_DEPTH(D)) bus ();
    fifo_rd_fwft #(.WIDTH(W), .BUF_DEPTH(D)) dut (.rclk(rclk), .rst_n(rst_n), .bus(bus));

    logic [W-1:0] src [NSRC];
    int rp      = 0;   // words the upstream FIFO has handed out
    int avail   = 0;   // words written into the upstream FIFO so far
    int landed  = 0;   // words captured into the output buffer
    int out_idx = 0;   // index of the next word the consumer should see
    bit presenting = 1'b0;
    int tests = 0;
    int fails = 0;

    // Upstream FIFO: registered empty flag that resets to 0, read data one cycle after the strobe.
    initial begin : upstream
        bit live;
        bit took;
        took           = 1'b0;
        bus.fifo_empty = 1'b0;
        bus.ram_rdata  = '0;
        forever begin
            @(posedge rclk);
            live = rst_n;
            #2;
            if (!live || !rst_n) begin
                bus.fifo_empty = 1'b0;
                bus.ram_rdata  = W'($urandom);
                presenting     = 1'b0;
                landed         = rp;
            end else begin
                if (presenting) landed++;
                presenting = took;
                if (took) begin
                    bus.ram_rdata = src[rp];
                    rp++;
                end else begin
                    bus.ram_rdata = W'($urandom);
                end
                bus.fifo_empty = (rp >= avail);
            end
            #6;
            took = bus.rd_inr && rst_n;
        end
    end

    always @(negedge rclk) begin
        if (rst_n) begin
            tests++;
            assert (bus.buf_level <= LVL_W'(D)) else begin
                fails++;
                $display("FAIL inv_level got=%0d max=%0d", bus.buf_level, D);
            end
            tests++;
            assert (!(bus.rd_inr && bus.fifo_empty)) else begin
                fails++;
                $display("FAIL inv_rd_while_empty rd_inr=%b fifo_empty=%b", bus.rd_inr, bus.fifo_empty);
            end
            tests++;
            assert (!(presenting && bus.buf_level == LVL_W'(D) && !(bus.out_valid && bus.out_ready))) else begin
                fails++;
                $display("FAIL inv_push_full level=%0d out_ready=%b", bus.buf_level, bus.out_ready);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        avail = rp;
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        tests++; if (bus.rd_inr !== 1'b0) begin fails++; $display("FAIL reset_rd_inr got=%b want=0", bus.rd_inr); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        tests++; if (bus.buf_level !== '0) begin fails++; $display("FAIL reset_level got=%0d want=0", bus.buf_level); end
        tests++; if (bus.out_data !== '0) begin fails++; $display("FAIL reset_out_data got=%h want=00", bus.out_data); end
        tick();
        rst_n = 1'b1;
        out_idx = rp;
        @(negedge rclk);
        tests++; if (bus.rd_inr !== 1'b0) begin fails++; $display("FAIL init_rd_inr got=%b want=0", bus.rd_inr); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL init_out_valid got=%b want=0", bus.out_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge rclk);
            tests++; if (bus.rd_inr !== 1'b0) begin fails++; $display("FAIL empty_rd_inr k=%0d got=%b want=0", k, bus.rd_inr); end
            tests++; if (bus.buf_level !== '0) begin fails++; $display("FAIL empty_level k=%0d got=%0d want=0", k, bus.buf_level); end
        end
    endtask

    task automatic test_single_word();
        int base;
        base = rp;
        src[base] = 8'hA5;
        bus.out_ready = 1'b1;
        avail = base + 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge rclk);
            tests++; if (bus.rd_inr !== (k == 0)) begin fails++; $display("FAIL single_rd_inr k=%0d got=%b want=%b", k, bus.rd_inr, k == 0); end
            tests++; if (bus.out_valid !== (k == 2)) begin fails++; $display("FAIL single_out_valid k=%0d got=%b want=%b", k, bus.out_valid, k == 2); end
            if (k == 2) begin
                tests++; if (bus.out_data !== 8'hA5) begin fails++; $display("FAIL single_out_data got=%h want=a5", bus.out_data); end
            end
        end
        out_idx = base + 1;
    endtask

    task automatic test_streaming();
        int base;
        base = rp;
        for (int i = 0; i < 16; i++) src[base + i] = W'(i);
        bus.out_ready = 1'b1;
        avail = base + 16;
        for (int k = 0; k < 20; k++) begin
            tick();
            @(negedge rclk);
            tests++; if (bus.rd_inr !== (k < 16)) begin fails++; $display("FAIL stream_rd_inr k=%0d got=%b want=%b", k, bus.rd_inr, k < 16); end
            tests++; if (bus.out_valid !== (k >= 2 && k < 18)) begin fails++; $display("FAIL stream_out_valid k=%0d got=%b", k, bus.out_valid); end
            if (k >= 2 && k < 18) begin
                tests++; if (bus.out_data !== W'(k - 2)) begin fails++; $display("FAIL stream_out_data k=%0d got=%h want=%h", k, bus.out_data, W'(k - 2)); end
            end
        end
        out_idx = base + 16;
    endtask

    task automatic test_back_pressure();
        int base;
        int strobes;
        int idx;
        base = rp;
        strobes = 0;
        avail = base + 20;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge rclk);
            if (bus.rd_inr) strobes++;
            if (k >= 2) begin
                tests++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== src[base]) begin
                    fails++; $display("FAIL bp_hold k=%0d got=%b/%h want=1/%h", k, bus.out_valid, bus.out_data, src[base]);
                end
            end
        end
        tests++; if (strobes !== D) begin fails++; $display("FAIL bp_strobes got=%0d want=%0d", strobes, D); end
        tests++; if (bus.buf_level !== LVL_W'(D)) begin fails++; $display("FAIL bp_level got=%0d want=%0d", bus.buf_level, D); end
        idx = base;
        for (int k = 0; k < 40; k++) begin
            tick();
            bus.out_ready = 1'b1;
            @(negedge rclk);
            if (bus.rd_inr) strobes++;
            if (bus.out_valid) begin
                tests++; if (bus.out_data !== src[idx]) begin fails++; $display("FAIL bp_resume idx=%0d got=%h want=%h", idx, bus.out_data, src[idx]); end
                idx++;
            end
        end
        tests++; if (idx !== base + 20) begin fails++; $display("FAIL bp_total got=%0d want=20", idx - base); end
        tests++; if (strobes !== 20) begin fails++; $display("FAIL bp_strobes_total got=%0d want=20", strobes); end
        out_idx = idx;
    endtask

    task automatic test_random();
        int p_ready;
        int p_data;
        int lvl;
        bit pop;
        logic exp_rd;
        p_ready = 100;
        p_data  = 100;
        for (int c = 0; c < 10000; c++) begin
            tick();
            if (c % 500 == 0) begin
                p_ready = int'($urandom_range(10, 100));
                p_data  = int'($urandom_range(0, 100));
            end
            bus.out_ready = (int'($urandom_range(1, 100)) <= p_ready);
            if (avail < NSRC && int'($urandom_range(1, 100)) <= p_data) avail++;
            @(negedge rclk);
            lvl    = landed - out_idx;
            pop    = (lvl != 0) && bus.out_ready;
            exp_rd = !bus.fifo_empty && (lvl + int'(presenting) - int'(pop)) < D;
            tests++; if (bus.rd_inr !== exp_rd) begin fails++; $display("FAIL rand_rd_inr c=%0d got=%b want=%b", c, bus.rd_inr, exp_rd); end
            tests++; if (bus.buf_level !== LVL_W'(lvl)) begin fails++; $display("FAIL rand_level c=%0d got=%0d want=%0d", c, bus.buf_level, lvl); end
            tests++; if (bus.out_valid !== (lvl != 0)) begin fails++; $display("FAIL rand_out_valid c=%0d got=%b want=%b", c, bus.out_valid, lvl != 0); end
            if (lvl != 0) begin
                tests++; if (bus.out_data !== src[out_idx]) begin fails++; $display("FAIL rand_order c=%0d got=%h want=%h", c, bus.out_data, src[out_idx]); end
            end
            if (pop) out_idx++;
        end
    endtask

    task automatic test_reset_mid_stream();
        bit reached;
        int old_idx;
        int got;
        tick();
        bus.out_ready = 1'b1;
        avail = rp;
        for (int k = 0; k < 20; k++) begin
            @(negedge rclk);
            if (bus.out_valid) begin
                tests++; if (bus.out_data !== src[out_idx]) begin fails++; $display("FAIL mid_drain got=%h want=%h", bus.out_data, src[out_idx]); end
                out_idx++;
            end
            tick();
        end
        bus.out_ready = 1'b0;
        avail = rp + 10;
        reached = 1'b0;
        for (int k = 0; k < 10 && !reached; k++) begin
            @(negedge rclk);
            if (landed - out_idx == 2 && presenting) reached = 1'b1;
            else tick();
        end
        tests++; if (!reached) begin fails++; $display("FAIL mid_setup got=level%0d want=level2_inflight", landed - out_idx); end
        tests++; if (bus.buf_level !== LVL_W'(2)) begin fails++; $display("FAIL mid_pre_level got=%0d want=2", bus.buf_level); end
        #1;
        rst_n = 1'b0;
        old_idx = out_idx;
        src[rp] = ~src[old_idx];
        #1;
        tests++; if (bus.rd_inr !== 1'b0) begin fails++; $display("FAIL mid_rd_inr got=%b want=0", bus.rd_inr); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid got=%b want=0", bus.out_valid); end
        tests++; if (bus.buf_level !== '0) begin fails++; $display("FAIL mid_level got=%0d want=0", bus.buf_level); end
        tests++; if (bus.out_data !== '0) begin fails++; $display("FAIL mid_out_data got=%h want=00", bus.out_data); end
        repeat (2) tick();
        rst_n = 1'b1;
        out_idx = rp;
        bus.out_ready = 1'b1;
        @(negedge rclk);
        tests++; if (bus.rd_inr !== 1'b0) begin fails++; $display("FAIL mid_init_rd_inr got=%b want=0", bus.rd_inr); end
        got = 0;
        for (int k = 0; k < 12 && got < 3; k++) begin
            tick();
            @(negedge rclk);
            if (bus.out_valid) begin
                tests++; if (bus.out_data !== src[out_idx]) begin fails++; $display("FAIL mid_resume n=%0d got=%h want=%h", got, bus.out_data, src[out_idx]); end
                out_idx++;
                got++;
            end
        end
        tests++; if (got !== 3) begin fails++; $display("FAIL mid_resume_count got=%0d want=3", got); end
    endtask

    initial begin : main
        for (int i = 0; i < NSRC; i++) src[i] = W'($urandom);
        bus.out_ready = 1'b0;
        test_reset();
        test_single_word();
        test_streaming();
        test_back_pressure();
        test_random();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_rd_fwft.md
# fifo_rd_fwft

Read-side output stage of the async FIFO, directly downstream of the read-pointer/empty logic in the read clock domain. It turns the registered `fifo_empty` flag and the 1-cycle-latency RAM read port into a first-word-fall-through valid/ready stream. It owns `rd_inr`, the read-pointer increment, and sustains one word per cycle through a small output buffer. It never over-reads the FIFO or overflows its own buffer.

## Interface
- `WIDTH`, 8, data word width.
- `BUF_DEPTH`, 2, output buffer entries; legal values are 2 and 4.
- `rclk`  in  1  read-domain clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `fifo_empty`  in  1  registered empty flag from the read-pointer stage. It already accounts for the previous cycle's `rd_inr`.
- `rd_inr`  out  1  read strobe. Advances the read pointer and issues a RAM read in the same cycle.
- `ram_rdata`  in  WIDTH  RAM read data. Valid exactly one cycle after the `rd_inr` that requested it.
- `out_data`  out  WIDTH  head-of-buffer word, registered.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.
- `buf_level`  out  $clog2(BUF_DEPTH)+1  number of words currently held in the buffer.

## Operation
- **Storage.** Circular buffer of `BUF_DEPTH` entries.
  - Write pointer, read pointer and `buf_level` counter, all registered.
  - `out_data` is the entry at the buffer read pointer.
  - `out_valid` = (`buf_level` != 0).
- **Init state.** A one-cycle `init` flag is set by reset and cleared on the first `rclk` edge after `rst_n` rises.
  - `rd_inr` is forced to 0 while `init` = 1.
  - This is required because the upstream `fifo_empty` resets to 0 even though the FIFO is empty.
- **In-flight tracking.** `inflight` is a 1-bit register equal to the previous cycle's `rd_inr`. When `inflight` = 1, `ram_rdata` is written into the buffer at the write pointer.
- **Pop.** `pop` = `out_valid & out_ready`. On pop, the read pointer advances and `buf_level` decrements.
- **Issue rule.** `rd_inr` = ~`init` & ~`fifo_empty` & ((`buf_level` + `inflight` − `pop`) < `BUF_DEPTH`).
  - The arithmetic is evaluated one bit wider than `buf_level` so it cannot wrap.
- **Level update.** `buf_level_next` = `buf_level` + `inflight` − `pop`. A simultaneous push and pop leaves the level unchanged.
- **Pointer wrap.** Buffer pointers wrap modulo `BUF_DEPTH`; `BUF_DEPTH` is a power of two, so a natural wrap is sufficient.
- **Ordering.** Words leave in exactly the order read from the RAM. No word is dropped or duplicated.
- **Stall.** While `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_valid` hold stable.
- **Invariants (asserted in the bench).**
  - `buf_level` ≤ `BUF_DEPTH` at all times.
  - A push never happens when `buf_level` = `BUF_DEPTH` unless `pop` is asserted in the same cycle.
  - `rd_inr` is never 1 while `fifo_empty` = 1.
- **Almost-empty flag.** `fifo_almost_empty` is not consumed by this block.

## Timing
- **Reset values.** `out_valid` 0, `out_data` 0, `buf_level` 0, `inflight` 0, `init` 1, buffer pointers 0. `rd_inr` is 0 throughout reset and during the `init` cycle.
- **Latency.** If `fifo_empty` is 0 in cycle t and there is room, then:
  - `rd_inr` = 1 in cycle t;
  - `ram_rdata` is captured at the end of cycle t+1;
  - `out_valid` = 1 in cycle t+2.
- **Throughput.** With `BUF_DEPTH` ≥ 2, a non-empty FIFO and `out_ready` held at 1, the block sustains one word per cycle. `rd_inr` stays high continuously.
- **Combinational path.** `rd_inr` depends combinationally on `out_ready`, `fifo_empty` and registered state only. There is no path from `ram_rdata`.
- **Consumer stall.** When `out_ready` drops with the buffer full, `rd_inr` deasserts in the same cycle.
  - The one in-flight word still lands, because the credit already counted it.
- **FIFO drains to empty.** `rd_inr` stops in the cycle `fifo_empty` = 1.
  - The buffer continues to drain to the consumer.
  - `out_valid` falls the cycle after the last pop.
- **Reset mid-operation.** Asynchronous clear of all state.
  - Buffered and in-flight words are discarded.
  - `rd_inr` drops immediately.

## Test plan
- **Reset and init.** Assert `rst_n` = 0, release, hold `fifo_empty` = 0 for the first cycle → `rd_inr` = 0 in the init cycle, `out_valid` = 0, `buf_level` = 0.
- **Single word.** Provide one word: `fifo_empty` 1→0 in cycle t, `ram_rdata` = 8'hA5 in t+1, `out_ready` = 1 → `rd_inr` is high only in t, `out_valid` = 1 with `out_data` = 8'hA5 in t+2, and back to 0 in t+3.
- **Streaming.** 16 words 0x00..0x0F, `fifo_empty` = 0 throughout, `out_ready` = 1 → `rd_inr` high for 16 consecutive cycles and 16 consecutive outputs 0x00..0x0F in order.
- **Back-pressure.** Hold `out_ready` = 0 with a non-empty FIFO → `rd_inr` issues exactly `BUF_DEPTH` strobes, `buf_level` saturates at `BUF_DEPTH`, and `out_data` holds.
  - Raising `out_ready` then resumes in-order output with no loss.
- **Random.** Randomise `out_ready` and `fifo_empty` (respecting the upstream semantics) over 10k cycles against a scoreboard → no drop, duplicate or reorder; invariants hold; `rd_inr` never asserts while `fifo_empty` = 1.
- **Reset mid-stream.** Pulse `rst_n` low with `buf_level` = 2 and `inflight` = 1 → all outputs return to their reset values asynchronously, and after release the next word is the first word read post-reset.
